uart_rx_fifo: RTL

Receive-side buffer that sits directly downstream of the UART receiver. It captures each completed character on the receiver's one-cycle done strobe and holds it in a circular FIFO. The host side drains it with a first-word-fall-through read port. Status flags are full, empty, almost-full and a sticky overrun flag for characters dropped while full.

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 68 ++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Host/receiver-facing signal bundle of the UART receive FIFO.
// The master side strobes characters in and pops them; the slave side is the FIFO.
interface uart_rx_fifo_if #(
    parameter int unsigned DBIT   = 8,
    parameter int unsigned ADDR_W = 4
);
    logic            wr;
    logic [DBIT-1:0] w_data;
    logic            rd;
    logic            clr_overrun;
    logic [DBIT-1:0] r_data;
    logic            empty;
    logic            full;
    logic            almost_full;
    logic [ADDR_W:0] count;
    logic            overrun;

    modport master (
        output wr, w_data, rd, clr_overrun,
        input  r_data, empty, full, almost_full, count, overrun
    );

    modport slave (
        input  wr, w_data, rd, clr_overrun,
        output r_data, empty, full, almost_full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO behind the UART receiver: captures characters on the done strobe,
// first-word-fall-through read port, full/empty/almost-full flags and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int unsigned DBIT     = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 12
) (
    input logic             clk,
    input logic             reset_n,
    uart_rx_fifo_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CountAf   = (ADDR_W + 1)'(AF_LEVEL);

    logic [DBIT-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wp_q, rp_q;
    logic [ADDR_W:0]   count_q;
    logic              overrun_q;
    logic              full, empty, wr_en, rd_en;

    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);

    // A write into a full FIFO still fits when the head is popped in the same cycle.
    assign wr_en = bus.wr & (~full | bus.rd);
    assign rd_en = bus.rd & ~empty;

    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[wp_q] <= bus.w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wp_q <= wp_q + 1'b1;
            end
            if (rd_en) begin
                rp_q <= rp_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Set has priority over a coincident clear.
            if (bus.wr && full && !bus.rd) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.r_data      = mem[rp_q];
    assign bus.empty       = empty;
    assign bus.full        = full;
    assign bus.almost_full = (count_q >= CountAf);
    assign bus.count       = count_q;
    assign bus.overrun     = overrun_q;
endmodule
